mm_uart_sequencer: RTL
======================

// Module: mm_uart_sequencer
// PURPOSE
//  Host-side controller for the 16x16 byte matrix multiplier. Parses a byte
//  command stream from the UART receiver, loads matrix memories A and B, and
//  launches the multiplier. It waits for completion, then streams the result
//  memory back through the UART transmitter. It sits between the uart_rx/uart_tx
//  pair and the multiplier's memory write and read ports.
// PARAMETERS
//  N           16      matrix dimension; memories hold N*N bytes, row-major
//  AW          8       memory address width, >= clog2(N*N)
//  TIMEOUT_CYC 65535   max cycles in WAIT_DONE before a timeout is reported
// PORTS
//  clk       in   1   clock
//  rst_n     in   1   asynchronous active-low reset
//  rx_data   in   8   received byte; valid only while rx_valid=1
//  rx_valid  in   1   one-cycle strobe per received byte; there is no backpressure
//  tx_data   out  8   byte to transmit
//  tx_valid  out  1   tx_data valid; held until accepted
//  tx_ready  in   1   transmitter accepts the byte when tx_valid&&tx_ready
//  a_we      out  1   write strobe for memory A
//  b_we      out  1   write strobe for memory B
//  w_addr    out  AW  shared write address for A and B
//  w_data    out  8   shared write data for A and B
//  mm_start  out  1   one-cycle start pulse to the multiplier
//  mm_done   in   1   one-cycle completion pulse from the multiplier
//  r_raddr   out  AW  result memory read address; 1-cycle read latency
//  r_rdata   in   8   result memory read data
//  busy      out  1   high whenever state != IDLE
//  rx_drop   out  1   one-cycle pulse when a byte arrives in a non-accepting state
// BEHAVIOUR
//  Reset value of every output is 0, state is IDLE and cnt is 0. Reset
//  mid-operation abandons the command immediately. Memories are not cleared.
//  All outputs are registered.
//  Commands are decoded in IDLE on rx_valid:
//   0x41 'A' -> LOAD_A; 0x42 'B' -> LOAD_B; 0x47 'G' -> START;
//   0x52 'R' -> RD_ADDR with cnt=0; any other byte -> SEND_ACK with byte 0x3F '?'.
//  LOAD_A / LOAD_B:
//   - On each rx_valid, the next cycle has a_we (or b_we)=1, w_addr=cnt,
//     w_data=rx_data, and cnt increments.
//   - Strobes are high for exactly 1 cycle.
//   - When the write with cnt==N*N-1 completes: cnt->0, go to SEND_ACK with 0x4B 'K'.
//  START: mm_start=1 for exactly one cycle, then WAIT_DONE with tmo=0.
//  WAIT_DONE:
//   - tmo increments every cycle.
//   - mm_done -> SEND_ACK with 'K'.
//   - tmo==TIMEOUT_CYC-1 without mm_done -> SEND_ACK with 0x54 'T'.
//   - If mm_done and the timeout coincide, mm_done wins.
//  SEND_ACK: tx_valid=1 with the ack byte. On tx_valid&&tx_ready, clear tx_valid
//  and go to IDLE.
//  Result readback:
//   - RD_ADDR: r_raddr=cnt, go to RD_WAIT.
//   - RD_WAIT: one cycle for read latency, then SEND_BYTE.
//   - SEND_BYTE: tx_data=r_rdata as captured at the end of RD_WAIT. tx_valid=1
//     until tx_ready.
//   - On handshake: if cnt==N*N-1, cnt->0 and go to IDLE. Otherwise cnt++ and
//     go to RD_ADDR.
//   - Minimum 3 cycles per byte. tx_data must stay stable while tx_valid=1.
//  A new tx_valid is never asserted in the cycle tx_valid drops.
//  cnt is AW+1 bits wide and never wraps past N*N-1.
//  rx_valid outside IDLE/LOAD_A/LOAD_B: the byte is discarded and rx_drop pulses.
//  mm_done outside WAIT_DONE is ignored.
// TESTING
//  1. 'A' + 256 bytes 0..255 -> 256 single-cycle a_we; w_addr==w_data==k;
//     b_we never high; then tx 0x4B.
//  2. 'G'; model asserts mm_done 500 cycles after mm_start -> exactly one
//     mm_start; busy high throughout; tx 0x4B.
//  3. 'G' with TIMEOUT_CYC=64 and no mm_done -> tx 0x54 after 64 cycles in
//     WAIT_DONE; the late mm_done that follows is ignored.
//  4. 'R' with result mem[k]=~k and tx_ready toggling 1-in-3 -> 256 bytes
//     0xFF..0x00 in order; tx_data stable while stalled.
//  5. 0x5A in IDLE -> tx 0x3F. A byte sent during WAIT_DONE -> rx_drop pulse,
//     state unaffected.
//  6. rst_n low after 100 bytes of LOAD_A -> all outputs 0. A following
//     'B' + 256 bytes starts again at w_addr 0.

Source files
------------

// File: rtl/mm_uart_sequencer.sv
// Host-side command sequencer for the byte matrix multiplier: loads A/B over UART,
// launches the multiply, and streams the result memory back out.
module mm_uart_sequencer #(
  parameter int N           = 16,
  parameter int AW          = 8,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          a_we,
  output logic          b_we,
  output logic [AW-1:0] w_addr,
  output logic [7:0]    w_data,
  output logic          mm_start,
  input  logic          mm_done,
  output logic [AW-1:0] r_raddr,
  input  logic [7:0]    r_rdata,
  output logic          busy,
  output logic          rx_drop
);

  localparam int CW = AW + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N * N - 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [3:0] {
    ST_IDLE      = 4'd0,
    ST_LOAD_A    = 4'd1,
    ST_LOAD_B    = 4'd2,
    ST_START     = 4'd3,
    ST_WAIT_DONE = 4'd4,
    ST_SEND_ACK  = 4'd5,
    ST_RD_ADDR   = 4'd6,
    ST_RD_WAIT   = 4'd7,
    ST_SEND_BYTE = 4'd8
  } state_t;

  state_t          state_r;
  logic [CW-1:0]   cnt_r;
  logic [TW-1:0]   tmo_r;
  logic [7:0]      tx_data_r;
  logic            tx_valid_r;
  logic            a_we_r;
  logic            b_we_r;
  logic [AW-1:0]   w_addr_r;
  logic [7:0]      w_data_r;
  logic            mm_start_r;
  logic [AW-1:0]   r_raddr_r;
  logic            busy_r;
  logic            rx_drop_r;

  // Command FSM with all outputs registered; busy tracks every IDLE entry/exit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= '0;
      tmo_r      <= '0;
      tx_data_r  <= 8'h00;
      tx_valid_r <= 1'b0;
      a_we_r     <= 1'b0;
      b_we_r     <= 1'b0;
      w_addr_r   <= '0;
      w_data_r   <= 8'h00;
      mm_start_r <= 1'b0;
      r_raddr_r  <= '0;
      busy_r     <= 1'b0;
      rx_drop_r  <= 1'b0;
    end else begin
      a_we_r     <= 1'b0;
      b_we_r     <= 1'b0;
      mm_start_r <= 1'b0;
      rx_drop_r  <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (rx_valid) begin
            busy_r <= 1'b1;
            case (rx_data)
              8'h41:   state_r <= ST_LOAD_A;
              8'h42:   state_r <= ST_LOAD_B;
              8'h47:   state_r <= ST_START;
              8'h52: begin
                // Address is presented during RD_ADDR so data is ready in RD_WAIT.
                cnt_r     <= '0;
                r_raddr_r <= '0;
                state_r   <= ST_RD_ADDR;
              end
              default: begin
                tx_data_r  <= 8'h3F;
                tx_valid_r <= 1'b1;
                state_r    <= ST_SEND_ACK;
              end
            endcase
          end
        end
        ST_LOAD_A, ST_LOAD_B: begin
          if (rx_valid) begin
            a_we_r   <= (state_r == ST_LOAD_A);
            b_we_r   <= (state_r == ST_LOAD_B);
            w_addr_r <= cnt_r[AW-1:0];
            w_data_r <= rx_data;
            if (cnt_r == CNT_LAST) begin
              cnt_r      <= '0;
              tx_data_r  <= 8'h4B;
              tx_valid_r <= 1'b1;
              state_r    <= ST_SEND_ACK;
            end else begin
              cnt_r <= cnt_r + 1'b1;
            end
          end
        end
        ST_START: begin
          mm_start_r <= 1'b1;
          tmo_r      <= '0;
          state_r    <= ST_WAIT_DONE;
        end
        ST_WAIT_DONE: begin
          tmo_r <= tmo_r + 1'b1;
          if (mm_done) begin
            tx_data_r  <= 8'h4B;
            tx_valid_r <= 1'b1;
            state_r    <= ST_SEND_ACK;
          end else if (tmo_r == TMO_LAST) begin
            tx_data_r  <= 8'h54;
            tx_valid_r <= 1'b1;
            state_r    <= ST_SEND_ACK;
          end
        end
        ST_SEND_ACK: begin
          if (tx_ready) begin
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            state_r    <= ST_IDLE;
          end
        end
        ST_RD_ADDR: begin
          r_raddr_r <= cnt_r[AW-1:0];
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          tx_data_r  <= r_rdata;
          tx_valid_r <= 1'b1;
          state_r    <= ST_SEND_BYTE;
        end
        ST_SEND_BYTE: begin
          if (tx_ready) begin
            tx_valid_r <= 1'b0;
            if (cnt_r == CNT_LAST) begin
              cnt_r   <= '0;
              busy_r  <= 1'b0;
              state_r <= ST_IDLE;
            end else begin
              cnt_r     <= cnt_r + 1'b1;
              r_raddr_r <= cnt_r[AW-1:0] + 1'b1;
              state_r   <= ST_RD_ADDR;
            end
          end
        end
        default: begin
          tx_valid_r <= 1'b0;
          busy_r     <= 1'b0;
          state_r    <= ST_IDLE;
        end
      endcase
      if (rx_valid && (state_r != ST_IDLE) && (state_r != ST_LOAD_A) && (state_r != ST_LOAD_B)) begin
        rx_drop_r <= 1'b1;
      end
    end
  end

  assign tx_data  = tx_data_r;
  assign tx_valid = tx_valid_r;
  assign a_we     = a_we_r;
  assign b_we     = b_we_r;
  assign w_addr   = w_addr_r;
  assign w_data   = w_data_r;
  assign mm_start = mm_start_r;
  assign r_raddr  = r_raddr_r;
  assign busy     = busy_r;
  assign rx_drop  = rx_drop_r;

endmodule
